// File: rtl/map_table_recovery_sequencer.sv
// Sole driver of the map table command ports: arbitrates renames, checkpoint saves and
// branch resolutions, and on a failed checkpoint restore walks the ROB issuing reverts.
module map_table_recovery_sequencer #(
  parameter int ARCH_REG_W       = 5,
  parameter int PHYS_REG_W       = 6,
  parameter int ROB_INDEX_W      = 6,
  parameter int CHECKPOINT_COL_W = 2
) (
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        dispatch_rename_req,
  input  logic [ARCH_REG_W-1:0]       dispatch_rename_arch,
  input  logic [PHYS_REG_W-1:0]       dispatch_rename_phys,
  output logic                        dispatch_rename_ack,
  input  logic                        branch_save_req,
  input  logic [ROB_INDEX_W-1:0]      branch_save_ROB_index,
  output logic                        branch_save_ack,
  input  logic                        resolve_req,
  input  logic                        resolve_mispredict,
  input  logic [ROB_INDEX_W-1:0]      resolve_ROB_index,
  input  logic [CHECKPOINT_COL_W-1:0] resolve_safe_column,
  output logic                        resolve_ack,
  input  logic [ROB_INDEX_W-1:0]      rob_tail_index,
  output logic [ROB_INDEX_W-1:0]      rob_read_index,
  input  logic                        rob_read_writes_reg,
  input  logic [ARCH_REG_W-1:0]       rob_read_arch,
  input  logic [PHYS_REG_W-1:0]       rob_read_safe_phys,
  input  logic [PHYS_REG_W-1:0]       rob_read_spec_phys,
  output logic                        rob_set_tail_valid,
  output logic [ROB_INDEX_W-1:0]      rob_set_tail_index,
  output logic                        recovery_busy,
  output logic                        rename_valid,
  output logic [ARCH_REG_W-1:0]       rename_dest_arch_reg_tag,
  output logic [PHYS_REG_W-1:0]       rename_dest_phys_reg_tag,
  output logic                        revert_valid,
  output logic [ARCH_REG_W-1:0]       revert_dest_arch_reg_tag,
  output logic [PHYS_REG_W-1:0]       revert_safe_dest_phys_reg_tag,
  output logic [PHYS_REG_W-1:0]       revert_speculated_dest_phys_reg_tag,
  output logic                        save_checkpoint_valid,
  output logic [ROB_INDEX_W-1:0]      save_checkpoint_ROB_index,
  input  logic                        save_checkpoint_success,
  output logic                        restore_checkpoint_valid,
  output logic                        restore_checkpoint_speculate_failed,
  output logic [ROB_INDEX_W-1:0]      restore_checkpoint_ROB_index,
  output logic [CHECKPOINT_COL_W-1:0] restore_checkpoint_safe_column,
  input  logic                        restore_checkpoint_success
);

  typedef enum logic [1:0] {IDLE, WALK, FINISH} state_t;

  localparam logic [ROB_INDEX_W-1:0] ROB_ONE = ROB_INDEX_W'(1);

  state_t                 state, state_next;
  logic [ROB_INDEX_W-1:0] branch_idx, branch_idx_next;
  logic [ROB_INDEX_W-1:0] walk_ptr, walk_ptr_next;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      branch_idx <= '0;
      walk_ptr   <= '0;
    end else begin
      state      <= state_next;
      branch_idx <= branch_idx_next;
      walk_ptr   <= walk_ptr_next;
    end
  end

  // Outputs are gated by nRST so an asserted reset silences every command immediately.
  always_comb begin
    state_next                          = state;
    branch_idx_next                     = branch_idx;
    walk_ptr_next                       = walk_ptr;
    dispatch_rename_ack                 = 1'b0;
    branch_save_ack                     = 1'b0;
    resolve_ack                         = 1'b0;
    rob_read_index                      = '0;
    rob_set_tail_valid                  = 1'b0;
    rob_set_tail_index                  = '0;
    recovery_busy                       = 1'b0;
    rename_valid                        = 1'b0;
    rename_dest_arch_reg_tag            = '0;
    rename_dest_phys_reg_tag            = '0;
    revert_valid                        = 1'b0;
    revert_dest_arch_reg_tag            = '0;
    revert_safe_dest_phys_reg_tag       = '0;
    revert_speculated_dest_phys_reg_tag = '0;
    save_checkpoint_valid               = 1'b0;
    save_checkpoint_ROB_index           = '0;
    restore_checkpoint_valid            = 1'b0;
    restore_checkpoint_speculate_failed = 1'b0;
    restore_checkpoint_ROB_index        = '0;
    restore_checkpoint_safe_column      = '0;

    if (nRST) begin
      case (state)
        IDLE: begin
          if (resolve_req) begin
            restore_checkpoint_valid            = 1'b1;
            restore_checkpoint_speculate_failed = resolve_mispredict;
            restore_checkpoint_ROB_index        = resolve_ROB_index;
            restore_checkpoint_safe_column      = resolve_safe_column;
            if (!resolve_mispredict) begin
              resolve_ack = 1'b1;
            end else begin
              branch_idx_next = resolve_ROB_index;
              if (restore_checkpoint_success) begin
                state_next = FINISH;
              end else begin
                walk_ptr_next = rob_tail_index - ROB_ONE;
                state_next    = WALK;
              end
            end
          end else if (branch_save_req) begin
            save_checkpoint_valid     = 1'b1;
            save_checkpoint_ROB_index = branch_save_ROB_index;
            branch_save_ack           = save_checkpoint_success;
          end else if (dispatch_rename_req) begin
            rename_valid             = 1'b1;
            rename_dest_arch_reg_tag = dispatch_rename_arch;
            rename_dest_phys_reg_tag = dispatch_rename_phys;
            dispatch_rename_ack      = 1'b1;
          end
        end
        // Walk from the youngest entry down to the branch, undoing each rename.
        WALK: begin
          recovery_busy  = 1'b1;
          rob_read_index = walk_ptr;
          if (walk_ptr == branch_idx) begin
            state_next = FINISH;
          end else begin
            if (rob_read_writes_reg) begin
              revert_valid                        = 1'b1;
              revert_dest_arch_reg_tag            = rob_read_arch;
              revert_safe_dest_phys_reg_tag       = rob_read_safe_phys;
              revert_speculated_dest_phys_reg_tag = rob_read_spec_phys;
            end
            walk_ptr_next = walk_ptr - ROB_ONE;
          end
        end
        FINISH: begin
          recovery_busy      = 1'b1;
          rob_set_tail_valid = 1'b1;
          rob_set_tail_index = branch_idx + ROB_ONE;
          resolve_ack        = 1'b1;
          state_next         = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule
